// File: rtl/gvram_fetch_ctrl.sv
// gvram_fetch_ctrl
// Graphic VRAM bus sequencer for the 16 MHz graphics path. It produces the
// dot-cell counter and the display byte for the serialiser, and shares the
// single VRAM port between a fixed display-fetch slot (cnt 4..6) and CPU
// accesses that use a wait-state handshake.
// Optional feature: define GVRAM_READBACK_EN to enable CPU reads from VRAM.
// Without it CPU_DO is held at zero and CPU read cycles do not assert VRAM_nOE.
module gvram_fetch_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int VRAM_BYTES = 8000
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              nHBLANK,
    input  logic              nVBLANK,
    input  logic              CPU_nREQ,
    input  logic              CPU_WR,
    input  logic [ADDR_W-1:0] CPU_A,
    input  logic [7:0]        CPU_DI,
    output logic [7:0]        CPU_DO,
    output logic              CPU_nWAIT,
    output logic [ADDR_W-1:0] VA,
    input  logic [7:0]        VD_I,
    output logic [7:0]        VD_O,
    output logic              VD_OE,
    output logic              VRAM_nCE,
    output logic              VRAM_nOE,
    output logic              VRAM_nWE,
    output logic [7:0]        DATA,
    output logic [2:0]        cnt
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} cpu_state_t;

    localparam logic [ADDR_W-1:0] DA_LAST = ADDR_W'(VRAM_BYTES - 1);

    cpu_state_t        state;
    cpu_state_t        state_nxt;
    logic [ADDR_W-1:0] da;
    logic              nvblank_p0;
    logic              active;
    logic              fetch;
    logic              grant;
    logic              cpu_slot;
    logic              vblank_start;

    assign active       = nHBLANK & nVBLANK;
    assign fetch        = active && (cnt >= 3'd4) && (cnt <= 3'd6);
    // The window describes the cell in which ACC1 will run: ACC1 lands on
    // cnt 0 or 1, so the decision is taken while cnt is 7 or 0.
    assign grant        = !active || (cnt == 3'd7) || (cnt == 3'd0);
    assign cpu_slot     = (state == ACC1) || (state == ACC2);
    assign vblank_start = !nVBLANK && nvblank_p0;
    assign CPU_nWAIT    = !(!CPU_nREQ && (state != DONE));

    // Dot-cell counter: free-runs mod 8 while active, parked at 0 in blanking.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= 3'd0;
        end else if (active) begin
            cnt <= cnt + 3'd1;
        end else begin
            cnt <= 3'd0;
        end
    end

    // Display fetch: latch the byte and advance DA when leaving cnt 6;
    // blanking clears DATA, and the start of vertical blanking rewinds DA.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            DATA       <= 8'h00;
            da         <= '0;
            nvblank_p0 <= 1'b1;
        end else begin
            nvblank_p0 <= nVBLANK;
            if (!active) begin
                DATA <= 8'h00;
            end else if (cnt == 3'd6) begin
                DATA <= VD_I;
            end
            if (vblank_start) begin
                da <= '0;
            end else if (active && (cnt == 3'd6)) begin
                da <= (da == DA_LAST) ? '0 : da + 1'b1;
            end
        end
    end

    // CPU access state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CPU access sequencing: two bus cycles, then hold DONE until the request drops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!CPU_nREQ && grant) state_nxt = ACC1;
            ACC1: state_nxt = ACC2;
            ACC2: state_nxt = DONE;
            DONE: if (CPU_nREQ) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef GVRAM_READBACK_EN
    // CPU read data is captured at the end of the second access cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            CPU_DO <= 8'h00;
        end else if ((state == ACC2) && !CPU_WR) begin
            CPU_DO <= VD_I;
        end
    end
`else
    assign CPU_DO = 8'h00;
`endif

    // VRAM bus mux: the display slot always wins; CPU slots fall in cnt 0..3
    // or blanking, so the two never meet.
    always_comb begin
        VA       = '0;
        VD_O     = 8'h00;
        VD_OE    = 1'b0;
        VRAM_nCE = 1'b1;
        VRAM_nOE = 1'b1;
        VRAM_nWE = 1'b1;
        if (fetch) begin
            VA       = da;
            VRAM_nCE = 1'b0;
            VRAM_nOE = 1'b0;
        end else if (cpu_slot) begin
            VA       = CPU_A;
            VRAM_nCE = 1'b0;
            if (CPU_WR) begin
                VD_O     = CPU_DI;
                VD_OE    = 1'b1;
                VRAM_nWE = (state == ACC2) ? 1'b0 : 1'b1;
            end
`ifdef GVRAM_READBACK_EN
            else begin
                VRAM_nOE = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gvram_fetch_ctrl.sv
// tb_gvram_fetch_ctrl
// Bench for gvram_fetch_ctrl: directed scenarios followed by randomized
// blanking and CPU traffic, all compared against a cell/transaction level
// reference model and a shadow copy of VRAM.
module tb_gvram_fetch_ctrl;
    localparam int ADDR_W     = 13;
    localparam int VRAM_BYTES = 8000;
    localparam int MEM_N      = 1 << ADDR_W;
`ifdef GVRAM_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              nRST, nHBLANK, nVBLANK, CPU_nREQ, CPU_WR;
    logic [ADDR_W-1:0] CPU_A, VA;
    logic [7:0]        CPU_DI, CPU_DO, VD_I, VD_O, DATA;
    logic              CPU_nWAIT, VD_OE, VRAM_nCE, VRAM_nOE, VRAM_nWE;
    logic [2:0]        cnt;

    logic [7:0] vram    [MEM_N];
    logic [7:0] ref_mem [MEM_N];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_run, m_da, m_acc, wraps;
    logic [7:0] m_data, m_do;
    bit         m_vprev, wrap_pending;

    always #5 CLK = ~CLK;

    assign VD_I = (!VRAM_nCE && !VRAM_nOE) ? vram[VA] : 8'hEE;

    gvram_fetch_ctrl #(.ADDR_W(ADDR_W), .VRAM_BYTES(VRAM_BYTES)) dut (
        .CLK(CLK), .nRST(nRST), .nHBLANK(nHBLANK), .nVBLANK(nVBLANK),
        .CPU_nREQ(CPU_nREQ), .CPU_WR(CPU_WR), .CPU_A(CPU_A), .CPU_DI(CPU_DI),
        .CPU_DO(CPU_DO), .CPU_nWAIT(CPU_nWAIT), .VA(VA), .VD_I(VD_I),
        .VD_O(VD_O), .VD_OE(VD_OE), .VRAM_nCE(VRAM_nCE), .VRAM_nOE(VRAM_nOE),
        .VRAM_nWE(VRAM_nWE), .DATA(DATA), .cnt(cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 0;
        m_da    = 0;
        m_acc   = 0;
        m_data  = 8'h00;
        m_do    = 8'h00;
        m_vprev = 1'b1;
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    // m_run = number of consecutive active clocks, so the cell position is m_run % 8.
    // m_acc = how far the pending CPU transaction is: 0 none, 1/2 bus cycle, 3 finished.
    task automatic model_step();
        bit act = nHBLANK && nVBLANK;
        int c   = m_run % 8;
        case (m_acc)
            0: if (!CPU_nREQ && (!act || ((m_run + 1) % 8) < 2)) m_acc = 1;
            1: m_acc = 2;
            2: begin
                m_acc = 3;
                if (CPU_WR) ref_mem[CPU_A] = CPU_DI;
                else        m_do = RB ? ref_mem[CPU_A] : 8'h00;
            end
            default: if (CPU_nREQ) m_acc = 0;
        endcase
        if (!act) begin
            m_data = 8'h00;
        end else if (c == 6) begin
            m_data = ref_mem[m_da];
            if (m_da == VRAM_BYTES - 1) begin
                m_da = 0;
                wrap_pending = 1'b1;
            end else begin
                m_da++;
            end
        end
        if (!nVBLANK && m_vprev) m_da = 0;
        m_vprev = nVBLANK;
        m_run   = act ? m_run + 1 : 0;
    endtask

    task automatic check_cycle();
        bit                act   = nHBLANK && nVBLANK;
        int                c     = m_run % 8;
        logic              e_nce = 1'b1;
        logic              e_noe = 1'b1;
        logic              e_nwe = 1'b1;
        logic              e_oe  = 1'b0;
        logic [ADDR_W-1:0] e_va  = '0;
        logic [7:0]        e_vdo = 8'h00;
        if (act && c >= 4 && c <= 6) begin
            e_nce = 1'b0;
            e_noe = 1'b0;
            e_va  = ADDR_W'(m_da);
        end else if (m_acc == 1 || m_acc == 2) begin
            e_nce = 1'b0;
            e_va  = CPU_A;
            if (CPU_WR) begin
                e_oe  = 1'b1;
                e_vdo = CPU_DI;
                e_nwe = (m_acc != 2);
            end else begin
                e_noe = !RB;
            end
        end
        check("cnt", 32'(cnt), 32'(c));
        check("DATA", 32'(DATA), 32'(m_data));
        check("CPU_DO", 32'(CPU_DO), 32'(m_do));
        check("CPU_nWAIT", 32'(CPU_nWAIT), 32'(!(!CPU_nREQ && m_acc != 3)));
        check("VRAM_nCE", 32'(VRAM_nCE), 32'(e_nce));
        check("VRAM_nOE", 32'(VRAM_nOE), 32'(e_noe));
        check("VRAM_nWE", 32'(VRAM_nWE), 32'(e_nwe));
        check("VD_OE", 32'(VD_OE), 32'(e_oe));
        if (!e_nce) check("VA", 32'(VA), 32'(e_va));
        if (e_oe)   check("VD_O", 32'(VD_O), 32'(e_vdo));
        // VRAM outputs are stable for the rest of the cycle, so the write
        // taken here is the one the memory sees at the next rising edge.
        if (!VRAM_nCE && !VRAM_nWE) vram[VA] = VD_O;
    endtask

    task automatic cycle();
        model_step();
        @(negedge CLK);
        check_cycle();
    endtask

    initial begin
        int  k;
        int  da_b;
        int  seg;
        int  extra;
        bit  done;

        nRST = 1'b0; nHBLANK = 1'b1; nVBLANK = 1'b1;
        CPU_nREQ = 1'b1; CPU_WR = 1'b0; CPU_A = '0; CPU_DI = 8'h00;
        for (int i = 0; i < MEM_N; i++) begin
            vram[i] = 8'($urandom);
        end
        vram[0] = 8'hA5;
        vram[1] = 8'h3C;
        vram[13'h0200] = 8'hC3;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = vram[i];
        model_reset();
        wrap_pending = 1'b0;
        wraps = 0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_nCE", 32'(VRAM_nCE), 1);
        check("rst_nOE", 32'(VRAM_nOE), 1);
        check("rst_nWE", 32'(VRAM_nWE), 1);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_DATA", 32'(DATA), 0);
        check("rst_nWAIT", 32'(CPU_nWAIT), 1);
        check("rst_CPU_DO", 32'(CPU_DO), 0);
        check("rst_VA", 32'(VA), 0);
        check("rst_VD_OE", 32'(VD_OE), 0);
        check("rst_VD_O", 32'(VD_O), 0);
        nRST = 1'b1;

        // Display fetch of the first two cells
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (m_run % 8 == 4) check(i < 8 ? "fetch_VA0" : "fetch_VA1", 32'(VA), i < 8 ? 0 : 1);
            if (m_run % 8 == 7) check(i < 8 ? "fetch_A5" : "fetch_3C", 32'(DATA), i < 8 ? 32'hA5 : 32'h3C);
        end

        // CPU write requested at cnt 3 during active display
        while (m_run % 8 != 3) cycle();
        CPU_nREQ = 1'b0; CPU_WR = 1'b1; CPU_A = 13'h0100; CPU_DI = 8'h5A;
        done = 1'b0;
        for (int i = 0; i < 24 && !done; i++) begin
            cycle();
            if (!VRAM_nWE) check("wr_nWE_cnt", 32'(cnt), 1);
            if (CPU_nWAIT) begin
                check("wr_done_cnt", 32'(cnt), 2);
                done = 1'b1;
            end
        end
        check("wr_timeout", 32'(done), 1);
        CPU_nREQ = 1'b1;
        cycle();
        check("wr_mem", 32'(vram[13'h0100]), 32'h5A);

        // CPU read during horizontal blanking
        nHBLANK = 1'b0;
        repeat (3) cycle();
        CPU_nREQ = 1'b0; CPU_WR = 1'b0; CPU_A = 13'h0200;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            cycle();
            if (CPU_nWAIT) done = 1'b1;
        end
        check("rd_timeout", 32'(done), 1);
        check("rd_CPU_DO", 32'(CPU_DO), RB ? 32'hC3 : 32'h00);
        CPU_nREQ = 1'b1;
        cycle();

        // Reset pulse in the middle of a CPU write
        CPU_nREQ = 1'b0; CPU_WR = 1'b1; CPU_A = 13'h0300; CPU_DI = 8'h77;
        cycle();
        check("mid_nCE_pre", 32'(VRAM_nCE), 0);
        #2 nRST = 1'b0;
        #1;
        check("mid_nCE", 32'(VRAM_nCE), 1);
        check("mid_nWE", 32'(VRAM_nWE), 1);
        check("mid_nOE", 32'(VRAM_nOE), 1);
        check("mid_VD_OE", 32'(VD_OE), 0);
        check("mid_cnt", 32'(cnt), 0);
        check("mid_DATA", 32'(DATA), 0);
        CPU_nREQ = 1'b1;
        #1;
        check("mid_nWAIT", 32'(CPU_nWAIT), 1);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) cycle();
        check("mid_mem", 32'(vram[13'h0300]), 32'(ref_mem[13'h0300]));

        // Blanking falls in the middle of a fetch
        nHBLANK = 1'b1;
        while (m_run % 8 != 5) cycle();
        da_b = m_da;
        nHBLANK = 1'b0;
        cycle();
        check("abort_nCE", 32'(VRAM_nCE), 1);
        check("abort_nOE", 32'(VRAM_nOE), 1);
        check("abort_DATA", 32'(DATA), 0);
        nHBLANK = 1'b1;
        while (m_run % 8 != 4) cycle();
        check("abort_VA", 32'(VA), 32'(da_b));

        // Vertical blanking rewinds the display address
        k = 0;
        while (m_da != 123 && k < 3000) begin
            cycle();
            k++;
        end
        check("vbl_setup", 32'(k < 3000), 1);
        nVBLANK = 1'b0;
        repeat (12) cycle();
        nVBLANK = 1'b1;
        while (m_run % 8 != 4) cycle();
        check("vbl_VA", 32'(VA), 0);

        // Random blanking and CPU traffic until the display address wraps
        seg   = 400;
        extra = 0;
        wrap_pending = 1'b0;
        for (int i = 0; i < 80000 && !(wraps > 0 && extra > 300); i++) begin
            if (seg == 0) begin
                nHBLANK = !nHBLANK;
                seg = nHBLANK ? int'($urandom_range(300, 600)) : int'($urandom_range(3, 12));
            end
            seg--;
            if (!CPU_nREQ && m_acc == 3) begin
                CPU_nREQ = 1'b1;
            end else if (CPU_nREQ && m_acc == 0 && $urandom_range(0, 15) == 0) begin
                CPU_A    = ADDR_W'($urandom_range(0, MEM_N - 1));
                CPU_WR   = 1'($urandom_range(0, 1));
                CPU_DI   = 8'($urandom);
                CPU_nREQ = 1'b0;
            end
            cycle();
            if (wrap_pending && nHBLANK && nVBLANK && m_run % 8 == 4) begin
                check("wrap_VA", 32'(VA), 0);
                wraps++;
                wrap_pending = 1'b0;
            end
            if (wraps > 0) extra++;
        end
        check("wrap_seen", 32'(wraps > 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
